// File: rtl/freq_divider_pkg.sv
// Shared constants for the frequency divider slice.
// Optional feature macro: FREQ_DIVIDER_TC_PULSE_EN (see frequency_divider).
package freq_divider_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned CNT_RST   = 0;

endpackage

// File: rtl/freq_down_counter.sv
// Loadable down counter that reloads din at zero and flags the terminal-count edge.
module freq_down_counter
    import freq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             zero;

    assign zero = (cnt_q == '0);

    // tc marks an edge where the counter reloads from zero, not a plain load
    assign tc  = ~ld & en & zero;
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (ld) begin
            cnt_d = din;
        end else if (en) begin
            cnt_d = zero ? din : cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= WIDTH'(CNT_RST);
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/frequency_divider.sv
// Divide-by-2(P+1) clock generator; outSignal toggles on each terminal count.
// Define FREQ_DIVIDER_TC_PULSE_EN to add the registered tcPulse output.
module frequency_divider
    import freq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             countDownEn,
    input  logic             LdP,
    input  logic [WIDTH-1:0] pin,
    output logic             outSignal
`ifdef FREQ_DIVIDER_TC_PULSE_EN
    ,
    output logic             tcPulse
`endif
);

    logic             tc;
    logic [WIDTH-1:0] cnt;
    logic             out_q;
    logic             out_d;

    freq_down_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .ld  (LdP),
        .en  (countDownEn),
        .din (pin),
        .cnt (cnt),
        .tc  (tc)
    );

    assign out_d     = out_q ^ tc;
    assign outSignal = out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

`ifdef FREQ_DIVIDER_TC_PULSE_EN
    logic tcp_q;

    assign tcPulse = tcp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tcp_q <= 1'b0;
        end else begin
            tcp_q <= tc;
        end
    end
`endif

endmodule

// File: tb/tb_frequency_divider.sv
// Self-checking bench for frequency_divider: vector table plus scenario sequences.
module tb_frequency_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         countDownEn = 1'b0;
    logic         LdP = 1'b0;
    logic [W-1:0] pin = '0;
    logic         outSignal;
`ifdef FREQ_DIVIDER_TC_PULSE_EN
    logic         tcPulse;
`endif

    frequency_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .countDownEn (countDownEn),
        .LdP         (LdP),
        .pin         (pin),
        .outSignal   (outSignal)
`ifdef FREQ_DIVIDER_TC_PULSE_EN
        ,
        .tcPulse     (tcPulse)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         out;
        logic [W-1:0] cnt;
        logic         tcp;
    } exp_t;

    typedef struct {
        logic         r;
        logic         l;
        logic         e;
        logic [W-1:0] p;
        logic         out;
        logic [W-1:0] cnt;
    } vec_t;

    exp_t         sb[$];
    int           n_chk = 0;
    int           n_fail = 0;
    logic         m_out = 1'b0;
    logic [W-1:0] m_cnt = '0;
    logic         m_tcp = 1'b0;
    logic         last_out = 1'b0;
    logic         toggled = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: drive, predict, compare after the edge
    task automatic cyc(input logic r, input logic l, input logic e,
                       input logic [W-1:0] p, input bit use_tbl,
                       input logic t_out, input logic [W-1:0] t_cnt);
        exp_t ex;
        exp_t got;
        @(negedge clk);
        rst = r;
        LdP = l;
        countDownEn = e;
        pin = p;
        m_tcp = 1'b0;
        if (r) begin
            m_cnt = '0;
            m_out = 1'b0;
        end else if (l) begin
            m_cnt = p;
        end else if (e) begin
            if (m_cnt == '0) begin
                m_cnt = p;
                m_out = ~m_out;
                m_tcp = 1'b1;
            end else begin
                m_cnt = m_cnt - 1'b1;
            end
        end
        ex.out = use_tbl ? t_out : m_out;
        ex.cnt = use_tbl ? t_cnt : m_cnt;
        ex.tcp = m_tcp;
        sb.push_back(ex);
        last_out = outSignal;
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("outSignal", 32'(outSignal), 32'(got.out));
        chk("cnt", 32'(dut.u_cnt.cnt), 32'(got.cnt));
`ifdef FREQ_DIVIDER_TC_PULSE_EN
        chk("tcPulse", 32'(tcPulse), 32'(got.tcp));
`endif
        toggled = (outSignal != last_out);
    endtask

    task automatic step(input logic r, input logic l, input logic e,
                        input logic [W-1:0] p);
        cyc(r, l, e, p, 1'b0, 1'b0, '0);
    endtask

    vec_t vt[17];
    int   last_t;
    int   ntog;
    int   k;
    bit   seen;

    initial begin
        vt[0]  = '{1, 0, 0, 16'h0003, 0, 16'h0000};
        vt[1]  = '{1, 0, 0, 16'h0003, 0, 16'h0000};
        vt[2]  = '{0, 0, 1, 16'h0003, 1, 16'h0003};
        vt[3]  = '{0, 0, 1, 16'h0003, 1, 16'h0002};
        vt[4]  = '{0, 0, 1, 16'h0003, 1, 16'h0001};
        vt[5]  = '{0, 0, 1, 16'h0003, 1, 16'h0000};
        vt[6]  = '{0, 0, 1, 16'h0003, 0, 16'h0003};
        vt[7]  = '{0, 0, 0, 16'h0003, 0, 16'h0003};
        vt[8]  = '{0, 1, 1, 16'h0005, 0, 16'h0005};
        vt[9]  = '{0, 0, 1, 16'h0005, 0, 16'h0004};
        vt[10] = '{1, 1, 1, 16'h0005, 0, 16'h0000};
        vt[11] = '{0, 0, 1, 16'h0000, 1, 16'h0000};
        vt[12] = '{0, 0, 1, 16'h0000, 0, 16'h0000};
        vt[13] = '{0, 1, 0, 16'hFFFF, 0, 16'hFFFF};
        vt[14] = '{0, 0, 1, 16'hFFFF, 0, 16'hFFFE};
        vt[15] = '{1, 0, 0, 16'hFFFF, 0, 16'h0000};
        vt[16] = '{0, 0, 1, 16'hFFFF, 1, 16'hFFFF};

        for (int i = 0; i < 17; i++) begin
            cyc(vt[i].r, vt[i].l, vt[i].e, vt[i].p, 1'b1,
                vt[i].out, vt[i].cnt);
        end

        // Scenario 2: P=6 gives a toggle every 7 enabled cycles
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 6);
        last_t = 0;
        ntog = 0;
        for (int i = 1; i <= 1420; i++) begin
            step(0, 0, 1, 6);
            if (toggled) begin
                chk("p6_interval", 32'(i - last_t), 32'd7);
                last_t = i;
                ntog++;
            end
        end
        chk("p6_toggles", 32'(ntog), 32'd202);

        // Scenario 3: P=0 toggles every enabled cycle
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 0);
            chk("p0_toggle", 32'(toggled), 32'd1);
        end

        // Scenario 4: 5 disabled cycles delay the toggle by 5
        step(1, 0, 0, 0);
        step(0, 1, 0, 6);
        k = 0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 6);
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 6);
            k++;
            if (toggled) seen = 1;
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            step(0, 0, 1, 6);
            k++;
            if (toggled) seen = 1;
        end
        chk("hold_seen", 32'(seen), 32'd1);
        chk("hold_delay", 32'(k), 32'd12);

        // Scenario 5: reload mid-count restarts without a toggle
        step(1, 0, 0, 0);
        step(0, 1, 0, 6);
        step(0, 0, 1, 6);
        step(0, 0, 1, 6);
        chk("pre_ld_cnt", 32'(dut.u_cnt.cnt), 32'd4);
        step(0, 1, 1, 10);
        chk("ld_no_toggle", 32'(toggled), 32'd0);
        k = 0;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step(0, 0, 1, 10);
            k++;
            if (toggled) seen = 1;
        end
        chk("ld_seen", 32'(seen), 32'd1);
        chk("ld_delay", 32'(k), 32'd11);

        // pin change without a load only lands at the next reload
        step(1, 0, 0, 0);
        step(0, 1, 0, 2);
        step(0, 0, 1, 9);
        step(0, 0, 1, 9);
        step(0, 0, 1, 9);
        chk("pin_reload", 32'(dut.u_cnt.cnt), 32'd9);
        step(0, 0, 1, 9);

        // Scenario 6: reset while outSignal=1, cnt=3
        step(1, 0, 0, 0);
        step(0, 0, 1, 3);
        chk("pre_rst_out", 32'(outSignal), 32'd1);
        step(1, 1, 1, 3);
        chk("rst_out", 32'(outSignal), 32'd0);
        chk("rst_cnt", 32'(dut.u_cnt.cnt), 32'd0);
        step(0, 0, 1, 3);
        chk("post_rst_out", 32'(outSignal), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/frequency_divider.md
FREQUENCY_DIVIDER -- requirements
Module: frequency_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the counter and divisor width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset; it is synchronous and active-high.
REQ-004 The block SHALL have port countDownEn, input, 1 bit, count enable; when low the counter holds.
REQ-005 The block SHALL have port LdP, input, 1 bit, synchronous load of divisor pin into the counter.
REQ-006 The block SHALL have port pin, input, WIDTH bits, unsigned divisor value P.
REQ-007 The block SHALL have port outSignal, output, 1 bit, registered divided clock output.

Function
REQ-008 The block SHALL hold an internal WIDTH-bit down counter cnt and the register outSignal.
REQ-009 Edge priority SHALL be: rst, then LdP, then countDownEn, then hold.
REQ-010 With LdP=1 (rst=0), cnt SHALL load pin on the edge; outSignal is unchanged; countDownEn is ignored that cycle.
REQ-011 With LdP=0, countDownEn=1 and cnt!=0, cnt SHALL decrement by 1; outSignal unchanged.
REQ-012 With LdP=0, countDownEn=1 and cnt==0 (terminal count), cnt SHALL reload pin and outSignal SHALL toggle on the same edge.
REQ-013 With LdP=0 and countDownEn=0, cnt and outSignal SHALL hold.
REQ-014 In steady enabled operation outSignal SHALL toggle every P+1 enabled cycles, giving output period 2*(P+1) clk cycles at 50% duty.
REQ-015 P=0 SHALL toggle outSignal on every enabled cycle, for divide-by-2.
REQ-016 P=2^WIDTH-1 SHALL be legal, with no overflow; decrement never wraps because 0 always reloads.
REQ-017 A change to pin without LdP SHALL take effect at the next terminal-count reload.
REQ-018 LdP asserted mid-count SHALL restart the count from pin without a glitch on outSignal.
REQ-019 outSignal SHALL be driven directly from a flop, with no combinational path from any input.

Reset
REQ-020 On rst=1 at a clk edge, cnt SHALL become 0 and outSignal SHALL become 0, overriding LdP and countDownEn.
REQ-021 After reset with countDownEn=1 and no load, the first enabled edge SHALL be a terminal count: reload pin and set outSignal to 1.
REQ-022 Reset asserted mid-operation SHALL take effect on the next edge, with no partial state retained.

Configuration
REQ-023 Macro FREQ_DIVIDER_TC_PULSE_EN, when defined, SHALL add output port tcPulse (1 bit, registered), high for exactly one cycle after each terminal-count edge and 0 in reset.
REQ-024 Without FREQ_DIVIDER_TC_PULSE_EN, port tcPulse and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-025 A shared package freq_divider_pkg SHALL hold the WIDTH default constant (16) and the counter reset value constant (0).
REQ-026 The down counter SHALL be a sub-module freq_down_counter with ports clk, rst, ld, en, din, cnt and tc.
REQ-027 The top level SHALL contain only the output toggle flop, the optional tcPulse flop, and the instantiation.

Verification
REQ-028 Scenario 1: rst=1 for 2 cycles -> outSignal=0 and cnt=0.
REQ-029 Scenario 2: pin=6, LdP=1 for 1 cycle, then countDownEn=1 -> outSignal toggles every 7 cycles, period 14 cycles, sustained for at least 100 periods.
REQ-030 Scenario 3: pin=0, load, enable -> outSignal toggles every cycle.
REQ-031 Scenario 4: pin=6, enable for 3 cycles, countDownEn=0 for 5 cycles, then re-enable -> the toggle is delayed by exactly 5 cycles.
REQ-032 Scenario 5: pin=10 while counting, LdP pulse at cnt=4 -> the next toggle comes 11 cycles after the load, with no toggle at the load edge.
REQ-033 Scenario 6: rst pulse while outSignal=1 and cnt=3 -> next edge gives outSignal=0 and cnt=0; with FREQ_DIVIDER_TC_PULSE_EN defined, tcPulse is one cycle wide per toggle.
